// File: rtl/irc_line_framer.sv
// IRC line framer: turns a raw received byte stream into trimmed, LF-framed lines
// held in a single line buffer and replayed one byte per cycle to the parser.
module irc_line_framer #(
    parameter int MAX_LEN = 512,
    parameter int LEN_W   = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_first,
    output logic             out_last,
    output logic [LEN_W-1:0] out_len,
    output logic             out_trunc,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] trunc_count
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    function automatic logic is_ws(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09) || (b == 8'h0B) || (b == 8'h0C);
    endfunction

    logic [7:0]       line_mem_r [0:MAX_LEN-1];
    logic [0:0]       state_r;
    logic [LEN_W-1:0] wr_ptr_r;
    logic [LEN_W-1:0] trim_len_r;
    logic             trunc_r;
    logic [LEN_W-1:0] rd_idx_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic             out_first_r;
    logic             out_last_r;
    logic [LEN_W-1:0] out_len_r;
    logic             out_trunc_r;
    logic [CNT_W-1:0] line_count_r;
    logic [CNT_W-1:0] trunc_count_r;

    logic             in_fire_s;
    logic             out_fire_s;
    logic             byte_cr_s;
    logic             byte_lf_s;
    logic             byte_ws_s;
    logic             lead_ws_s;
    logic             room_s;
    logic             store_s;
    logic [LEN_W-1:0] next_idx_s;
    logic [LEN_W-1:0] last_idx_s;

    // Decode of the incoming byte and the handshake strobes.
    always_comb begin
        in_fire_s  = in_valid && in_ready_r && (state_r == S_FILL) && !rst;
        out_fire_s = out_valid_r && out_ready;
        byte_cr_s  = (in_data == CH_CR);
        byte_lf_s  = (in_data == CH_LF);
        byte_ws_s  = is_ws(in_data);
        lead_ws_s  = byte_ws_s && (wr_ptr_r == LEN_ZERO);
        room_s     = (wr_ptr_r < LEN_MAX);
        store_s    = in_fire_s && !byte_cr_s && !byte_lf_s && !lead_ws_s && room_s;
        next_idx_s = rd_idx_r + LEN_ONE;
        last_idx_s = out_len_r - LEN_ONE;
    end

    // Line storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            line_mem_r[wr_ptr_r[AW-1:0]] <= in_data;
        end
    end

    // Fill/emit state machine with registered output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FILL;
            wr_ptr_r      <= LEN_ZERO;
            trim_len_r    <= LEN_ZERO;
            trunc_r       <= 1'b0;
            rd_idx_r      <= LEN_ZERO;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'h00;
            out_first_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_len_r     <= LEN_ZERO;
            out_trunc_r   <= 1'b0;
            line_count_r  <= {CNT_W{1'b0}};
            trunc_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_FILL: begin
                    if (in_fire_s) begin
                        if (byte_lf_s) begin
                            if (trim_len_r == LEN_ZERO) begin
                                wr_ptr_r   <= LEN_ZERO;
                                trim_len_r <= LEN_ZERO;
                                trunc_r    <= 1'b0;
                            end else begin
                                out_len_r   <= trim_len_r;
                                out_trunc_r <= trunc_r;
                                rd_idx_r    <= LEN_ZERO;
                                out_valid_r <= 1'b1;
                                out_data_r  <= line_mem_r[0];
                                out_first_r <= 1'b1;
                                out_last_r  <= (trim_len_r == LEN_ONE);
                                in_ready_r  <= 1'b0;
                                state_r     <= S_EMIT;
                            end
                        end else if (!byte_cr_s && !lead_ws_s) begin
                            if (room_s) begin
                                wr_ptr_r <= wr_ptr_r + LEN_ONE;
                                if (!byte_ws_s) begin
                                    trim_len_r <= wr_ptr_r + LEN_ONE;
                                end
                            end else begin
                                // Overflow bytes, whitespace included, only mark the line.
                                trunc_r <= 1'b1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (out_fire_s) begin
                        if (out_last_r) begin
                            line_count_r <= line_count_r + CNT_W'(1);
                            if (out_trunc_r) begin
                                trunc_count_r <= trunc_count_r + CNT_W'(1);
                            end
                            wr_ptr_r    <= LEN_ZERO;
                            trim_len_r  <= LEN_ZERO;
                            trunc_r     <= 1'b0;
                            out_valid_r <= 1'b0;
                            out_first_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= S_FILL;
                        end else begin
                            rd_idx_r    <= next_idx_s;
                            out_data_r  <= line_mem_r[next_idx_s[AW-1:0]];
                            out_first_r <= 1'b0;
                            out_last_r  <= (next_idx_s == last_idx_s);
                        end
                    end
                end
                default: begin
                    state_r     <= S_FILL;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r && !rst;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_first   = out_first_r;
    assign out_last    = out_last_r;
    assign out_len     = out_len_r;
    assign out_trunc   = out_trunc_r;
    assign line_count  = line_count_r;
    assign trunc_count = trunc_count_r;

endmodule

// File: tb/tb_irc_line_framer.sv
// Randomized scoreboard bench for irc_line_framer: a line-level reference model
// queues expected output beats, and a negedge monitor pops and compares them.
module tb_irc_line_framer;

    localparam int MAX_LEN  = 512;
    localparam int LEN_W    = 10;
    localparam int CNT_W    = 8;
    localparam int BUDGET   = 5000;

    typedef struct packed {
        logic [7:0]       d;
        logic             f;
        logic             l;
        logic [LEN_W-1:0] len;
        logic             t;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_first;
    logic             out_last;
    logic [LEN_W-1:0] out_len;
    logic             out_trunc;
    logic [CNT_W-1:0] line_count;
    logic [CNT_W-1:0] trunc_count;

    irc_line_framer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_len(out_len),
        .out_trunc(out_trunc), .line_count(line_count), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               rmode = 0;
    int               beats = 0;
    exp_t             sb[$];
    logic [7:0]       line_q[$];
    logic [CNT_W-1:0] m_lines = '0;
    logic [CNT_W-1:0] m_trunc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic ws(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09) || (b == 8'h0B) || (b == 8'h0C);
    endfunction

    // Reference: strip CR, strip leading blanks, keep MAX_LEN, strip trailing blanks.
    task automatic model_line();
        logic [7:0] body[$];
        logic       tr;
        exp_t       e;
        foreach (line_q[i]) if (line_q[i] != 8'h0D) body.push_back(line_q[i]);
        while (body.size() > 0 && ws(body[0])) void'(body.pop_front());
        tr = (body.size() > MAX_LEN);
        while (body.size() > MAX_LEN) void'(body.pop_back());
        while (body.size() > 0 && ws(body[body.size()-1])) void'(body.pop_back());
        for (int i = 0; i < body.size(); i++) begin
            e.d   = body[i];
            e.f   = (i == 0);
            e.l   = (i == body.size() - 1);
            e.len = LEN_W'(body.size());
            e.t   = tr;
            sb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", n);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endtask

    task automatic end_line();
        model_line();
        foreach (line_q[i]) send_byte(line_q[i]);
        send_byte(8'h0A);
        line_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            errors++; checks++;
            $display("FAIL idle_timeout: %0d beats still expected", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Output-side ready pattern, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 1) == 1);
                2: out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare each transfer with the scoreboard and check stalls.
    initial begin
        logic pend = 1'b0;
        logic hold = 1'b0;
        logic [7:0] h_d;
        logic h_f, h_l;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                m_lines = '0; m_trunc = '0;
                pend = 1'b0; hold = 1'b0;
            end else begin
                if (pend) begin
                    chk("line_count", 32'(line_count), 32'(m_lines));
                    chk("trunc_count", 32'(trunc_count), 32'(m_trunc));
                    pend = 1'b0;
                end
                if (hold) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", {22'd0, out_data, out_first, out_last}, {22'd0, h_d, h_f, h_l});
                end
                hold = 1'b0;
                if (out_valid) chk("in_ready_during_emit", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_beat: got data %0h expected no output", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", {11'd0, out_data, out_first, out_last, out_len, out_trunc},
                                    {11'd0, e.d, e.f, e.l, e.len, e.t});
                        beats++;
                        if (e.l) begin
                            m_lines = m_lines + CNT_W'(1);
                            if (e.t) m_trunc = m_trunc + CNT_W'(1);
                            pend = 1'b1;
                        end
                    end
                end else if (out_valid) begin
                    hold = 1'b1;
                    h_d = out_data; h_f = out_first; h_l = out_last;
                end
            end
        end
    end

    initial begin
        logic [7:0] alpha [0:11];
        int         len;
        alpha = '{8'h61, 8'h62, 8'h4E, 8'h3A, 8'h23, 8'h20, 8'h20, 8'h09,
                  8'h0B, 8'h0C, 8'h0D, 8'h7A};

        @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outputs", {26'd0, out_valid, out_first, out_last, out_trunc, 2'b00}, 32'd0);
        chk("reset_len", 32'(out_len), 32'd0);
        chk("reset_counts", {16'd0, line_count, trunc_count}, 32'd0);

        push_str("PING :abc\r"); end_line(); wait_idle();
        chk("ping_count", 32'(line_count), 32'd1);

        push_str("  NICK x  \r"); end_line();
        push_str("\r"); end_line();
        push_str("   "); end_line();
        wait_idle();
        chk("empty_lines_uncounted", 32'(line_count), 32'd2);

        for (int i = 0; i < 600; i++) line_q.push_back(8'h41);
        end_line();
        push_str("X"); end_line(); wait_idle();
        chk("trunc_count_after_long", 32'(trunc_count), 32'd1);

        rmode = 2;
        push_str("JOIN #c"); end_line();
        push_str("PART"); end_line();
        wait_idle();
        rmode = 0;

        // Reset on the third beat of a ten-byte emission.
        beats = 0;
        push_str("ABCDEFGHIJ"); end_line();
        begin
            int n = 0;
            while (beats < 2 && n < BUDGET) begin
                @(posedge clk);
                n++;
            end
        end
        #2 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_mid_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_ready", 32'(in_ready), 32'd1);
        chk("post_reset_counts", {16'd0, line_count, trunc_count}, 32'd0);
        push_str("NEXT line"); end_line(); wait_idle();

        rmode = 1;
        for (int k = 0; k < 60; k++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(505, 530) : $urandom_range(0, 20);
            for (int i = 0; i < len; i++) line_q.push_back(alpha[$urandom_range(0, 11)]);
            end_line();
        end
        wait_idle();

        rmode = 0;
        for (int k = 0; k < 260; k++) begin
            push_str("X"); end_line();
        end
        wait_idle();
        chk("final_line_count", 32'(line_count), 32'(m_lines));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irc_line_framer.md
Name: irc_line_framer

Overview:
- Upstream stage of the IRC message parser.
- Turns the raw byte stream from the TCP receive path into complete, trimmed IRC lines; the parser consumes one line at a time.
- Frames on LF and discards CR; trims leading and trailing whitespace; drops empty lines; truncates lines longer than MAX_LEN and flags them.
- Single line buffer: input is stalled while a line is being emitted.

Parameters:
- MAX_LEN, 512, maximum stored bytes per line (IRC limit); excess bytes are dropped.
- LEN_W, 10, width of length and index fields; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an input byte is present.
- in_ready  out  1  the framer accepts the byte this cycle.
- in_data  in  8  raw received byte.
- out_valid  out  1  a line byte is presented.
- out_ready  in  1  the parser accepts the byte this cycle.
- out_data  out  8  current line byte.
- out_first  out  1  the current byte is the first byte of the line.
- out_last  out  1  the current byte is the last byte of the line.
- out_len  out  LEN_W  trimmed line length; stable for the whole emission.
- out_trunc  out  1  the line lost bytes to overflow; stable for the whole emission.
- line_count  out  CNT_W  number of lines fully emitted; wraps.
- trunc_count  out  CNT_W  number of emitted lines with out_trunc=1; wraps.

Behaviour:
- Reset values: in_ready=0 during the reset cycle and 1 afterwards (FILL state); out_valid=0, out_first=0, out_last=0, out_len=0, out_trunc=0, line_count=0, trunc_count=0.
- State machine has two states, FILL and EMIT.
- Handshakes:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - out_valid, once raised, stays high until the current byte is accepted.
  - out_data, out_first and out_last change only after an accepted transfer.
- FILL (in_ready=1):
  - CR (0x0D): discarded anywhere in the line; no state change.
  - Leading whitespace: whitespace bytes (0x20, 0x09, 0x0B, 0x0C) are discarded while wr_ptr=0.
  - Other non-LF bytes: if wr_ptr<MAX_LEN, store at buf[wr_ptr] and increment wr_ptr. If the byte is not whitespace, set trim_len=wr_ptr+1 (trailing-trim tracker).
  - Overflow: if wr_ptr=MAX_LEN, drop the byte and set the trunc flag. This applies to whitespace too.
  - LF (0x0A), trim_len=0: empty line. Clear wr_ptr, trim_len and trunc; stay in FILL; no output; counters unchanged.
  - LF (0x0A), trim_len>0: latch out_len=trim_len and out_trunc=trunc, set rd_idx=0, and go to EMIT. out_valid is 1 in the next cycle, so an accepted LF in cycle N gives the first output byte in cycle N+1.
- EMIT (in_ready=0):
  - Outputs: out_valid=1, out_data=buf[rd_idx], out_first=(rd_idx==0), out_last=(rd_idx==out_len-1). A one-byte line asserts first and last together.
  - Non-final accepted transfer: rd_idx increments.
  - Transfer with out_last=1:
    - line_count increments; trunc_count increments if out_trunc=1.
    - wr_ptr, trim_len and trunc clear.
    - State returns to FILL; in_ready=1 and out_valid=0 from the next cycle.
  - Trailing whitespace beyond trim_len is never emitted.
  - Throughput: one output byte per cycle while out_ready=1. No input is consumed during EMIT.
- Truncated line: only the first MAX_LEN stored bytes are kept; trailing trim then applies to those stored bytes. A line whose stored bytes are all whitespace is dropped as empty and not counted, even if trunc was set.
- Counters wrap modulo 2^CNT_W with no saturation.
- rst asserted in any state, including mid-EMIT: all state and outputs return to reset values on the next edge, and any partial line is lost.
- A byte presented while in_ready=0 is not consumed; the source holds it.

Test Plan:
- Input "PING :abc\r\n" with out_ready=1 -> output of 9 bytes "PING :abc"; first byte flagged out_first in the cycle after LF; out_last on 'c'; out_len=9; line_count=1.
- Input "  NICK x  \r\n" -> out_len=6, output "NICK x"; input "\r\n" followed by "   \n" -> no out_valid, line_count unchanged.
- 600 bytes of 'A' then LF, with MAX_LEN=512 -> 512 bytes emitted, out_trunc=1, trunc_count=1; the following line "X\n" gives out_len=1, first=last=1, out_trunc=0.
- Emit "JOIN #c" with out_ready toggling 1/0 every cycle -> data stable while stalled, 7 beats total, in_ready=0 throughout; the source's next byte is accepted only after out_last is transferred.
- Assert rst for one cycle on the 3rd beat of a 10-byte emission -> out_valid=0, in_ready=1 after reset, counters=0; the next line is framed correctly from its first byte.
- line_count preset by 65535 emitted lines, then one more -> line_count wraps to 0.
